// File: rtl/mac_operand_sequencer.sv
// Operand-pair FIFO feeding the MAC, framing the stream into vectors with first/last tags.
// Optional same-cycle bypass of the empty FIFO is enabled with `define MAC_SEQ_BYPASS_EN.
module mac_operand_sequencer #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 8,
    parameter int VLEN_W = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [VLEN_W-1:0] vec_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic              out_first,
    output logic              out_last,
    output logic              vec_done,
    output logic [CNT_W-1:0]  count
);

    logic [WIDTH-1:0]  mem_a_q [DEPTH];
    logic [WIDTH-1:0]  mem_b_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [VLEN_W-1:0] idx_q, idx_d;
    logic [VLEN_W-1:0] len_q, len_d;
    logic              vec_done_q, vec_done_d;

    logic              empty, full, bypass;
    logic              push, pop, wr_en, rd_en;
    logic [VLEN_W-1:0] eff_len;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));
`ifdef MAC_SEQ_BYPASS_EN
        bypass = empty && in_valid && !rst;
`else
        bypass = 1'b0;
`endif
        in_ready  = !rst && !full;
        out_valid = !empty || bypass;

        // Storage read data is masked while empty so idle outputs are a clean zero.
        out_a = '0;
        out_b = '0;
        if (!empty) begin
            out_a = mem_a_q[rd_ptr_q];
            out_b = mem_b_q[rd_ptr_q];
        end else if (bypass) begin
            out_a = in_a;
            out_b = in_b;
        end

        push  = in_valid && in_ready;
        pop   = out_valid && out_ready;
        rd_en = pop && !empty;
        wr_en = push && !(bypass && out_ready);

        // A length of 0 wraps to all-ones after the subtraction, i.e. 2^VLEN_W elements.
        eff_len   = (idx_q == '0) ? vec_len : len_q;
        out_first = (idx_q == '0);
        out_last  = (idx_q == eff_len - VLEN_W'(1));
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        len_d      = len_q;
        vec_done_d = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            idx_d    = '0;
            len_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

            if (pop) begin
                if (idx_q == '0) len_d = vec_len;
                if (out_last) begin
                    idx_d      = '0;
                    vec_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + VLEN_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            vec_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            vec_done_q <= vec_done_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    assign vec_done = vec_done_q;
    assign count    = count_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomised bench for mac_operand_sequencer against a queue-based reference model.
module tb_mac_operand_sequencer;

    localparam int DEPTH  = 4;
    localparam int WIDTH  = 8;
    localparam int VLEN_W = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef MAC_SEQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a = '0;
    logic [WIDTH-1:0]  in_b = '0;
    logic [VLEN_W-1:0] vec_len = 4'd4;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_a;
    logic [WIDTH-1:0]  out_b;
    logic              out_first;
    logic              out_last;
    logic              vec_done;
    logic [CNT_W-1:0]  count;

    mac_operand_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .VLEN_W(VLEN_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .vec_len(vec_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_first(out_first), .out_last(out_last), .vec_done(vec_done), .count(count)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_seen = 0;

    // Reference model: queue of pending pairs plus element position within the current vector.
    logic [2*WIDTH-1:0] mq[$];
    int elem_no  = 0;
    int cur_len  = 0;
    bit done_exp = 1'b0;

    // One clock cycle: compare DUT outputs against the model mid-cycle, then advance the model.
    task automatic step();
        int n, len;
        bit byp, e_ready, e_valid, e_first, e_last, push, pop;
        logic [2*WIDTH-1:0] head;
        @(negedge clk);
        n       = mq.size();
        byp     = BYPASS && n == 0 && in_valid && !rst;
        e_ready = !rst && n != DEPTH;
        e_valid = n != 0 || byp;
        head    = (n != 0) ? mq[0] : (byp ? {in_a, in_b} : '0);
        len     = (elem_no == 0) ? ((vec_len == 0) ? (1 << VLEN_W) : int'(vec_len)) : cur_len;
        e_first = (elem_no == 0);
        e_last  = (elem_no == len - 1);

        total_cnt++;
        if (in_ready !== e_ready) $display("FAIL in_ready: got %b expected %b at %0t", in_ready, e_ready, $time);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== e_valid) $display("FAIL out_valid: got %b expected %b at %0t", out_valid, e_valid, $time);
        else pass_cnt++;
        total_cnt++;
        if (count !== CNT_W'(n)) $display("FAIL count: got %0d expected %0d at %0t", count, n, $time);
        else pass_cnt++;
        total_cnt++;
        if ({out_a, out_b} !== head) $display("FAIL data: got %h expected %h at %0t", {out_a, out_b}, head, $time);
        else pass_cnt++;
        total_cnt++;
        if (vec_done !== done_exp) $display("FAIL vec_done: got %b expected %b at %0t", vec_done, done_exp, $time);
        else pass_cnt++;
        if (e_valid) begin
            total_cnt++;
            if ({out_first, out_last} !== {e_first, e_last})
                $display("FAIL first_last: got %b%b expected %b%b at %0t", out_first, out_last, e_first, e_last, $time);
            else pass_cnt++;
        end
        if (vec_done === 1'b1) done_seen++;

        push = in_valid && e_ready;
        pop  = e_valid && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            elem_no  = 0;
            done_exp = 1'b0;
        end else begin
            if (pop && n != 0) void'(mq.pop_front());
            if (push && !(byp && pop)) mq.push_back({in_a, in_b});
            done_exp = 1'b0;
            if (pop) begin
                if (elem_no == 0) cur_len = len;
                if (e_last) begin
                    elem_no  = 0;
                    done_exp = 1'b1;
                end else begin
                    elem_no++;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = v;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic_vector();
        logic [2*WIDTH-1:0] pairs [4];
        int d0;
        pairs[0] = 16'h0302; pairs[1] = 16'h0104; pairs[2] = 16'h0503; pairs[3] = 16'h0702;
        vec_len   = 4'd4;
        out_ready = 1'b1;
        d0 = done_seen;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pairs[i][15:8], pairs[i][7:0]);
            step();
        end
        idle(3);
        total_cnt++;
        if (done_seen - d0 !== 1) $display("FAIL basic_done_pulses: got %0d expected 1", done_seen - d0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom));
            step();
        end
        drive(1'b0, '0, '0);
        total_cnt++;
        if (count !== CNT_W'(DEPTH)) $display("FAIL bp_full_count: got %0d expected %0d", count, DEPTH);
        else pass_cnt++;
        out_ready = 1'b1;
        idle(6);
        total_cnt++;
        if (count !== '0) $display("FAIL bp_drain_count: got %0d expected 0", count);
        else pass_cnt++;
    endtask

    task automatic test_len_edges();
        int d0;
        out_ready = 1'b1;
        vec_len   = 4'd1;
        d0 = done_seen;
        drive(1'b1, 8'd1, 8'd1); step();
        drive(1'b1, 8'd0, 8'd0); step();
        idle(3);
        total_cnt++;
        if (done_seen - d0 !== 2) $display("FAIL len1_done_pulses: got %0d expected 2", done_seen - d0);
        else pass_cnt++;

        vec_len = 4'd0;
        d0 = done_seen;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom));
            step();
        end
        idle(3);
        total_cnt++;
        if (done_seen - d0 !== 1) $display("FAIL len0_done_pulses: got %0d expected 1", done_seen - d0);
        else pass_cnt++;
    endtask

    task automatic test_len_change();
        out_ready = 1'b1;
        vec_len   = 4'd4;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) vec_len = 4'd2;
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom));
            step();
        end
        idle(3);
    endtask

    task automatic test_flush();
        vec_len   = 4'd4;
        out_ready = 1'b1;
        drive(1'b1, 8'h11, 8'h22); step();
        drive(1'b1, 8'h33, 8'h44); step();
        drive(1'b0, '0, '0);       step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom));
            step();
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h55, 8'h66);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        total_cnt++;
        if ({count, out_valid} !== {CNT_W'(0), BYPASS && 1'b0}) $display("FAIL flush_clear: got count %0d valid %b expected 0 0", count, out_valid);
        else pass_cnt++;
        step();
        drive(1'b1, 8'h77, 8'h88); step();
        idle(3);
    endtask

    task automatic test_rst_mid();
        vec_len   = 4'd4;
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 8'h02); step();
        drive(1'b1, 8'h03, 8'h04); step();
        drive(1'b0, '0, '0);
        rst = 1'b1; step();
        rst = 1'b0; step();
        drive(1'b1, 8'h05, 8'h06); step();
        idle(2);
    endtask

    task automatic test_bypass();
        idle(2);
        out_ready = 1'b1;
        vec_len   = 4'd1;
        drive(1'b1, 8'd3, 8'd2);
        step();
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 15) == 0) vec_len = VLEN_W'($urandom);
            flush = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(8);
    endtask

    initial begin
        test_reset();
        test_basic_vector();
        test_backpressure();
        test_len_edges();
        test_len_change();
        test_flush();
        test_rst_mid();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Upstream feeder for the multiply-accumulate stage: buffers 8-bit operand pairs (a, b) in a small FIFO and streams them out over a valid/ready handshake.
- Frames the stream into dot-product vectors of programmable length.
- Tags each pair with first/last so the MAC clears its accumulator on the first element and presents its result after the last.
- Sits between the pin-level input capture and the MAC core.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- WIDTH, 8, operand width in bits.
- VLEN_W, 4, width of the vector-length field; vec_len = 0 means 2^VLEN_W elements.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous clear of FIFO and framing state; does not change the vec_len sampling rule
- in_valid  input  1  producer has a pair on in_a/in_b
- in_ready  output  1  FIFO can accept a pair
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- vec_len  input  VLEN_W  elements per vector; sampled at the start of each vector
- out_valid  output  1  pair available to the MAC
- out_ready  input  1  MAC accepts the pair
- out_a  output  WIDTH  operand a to the MAC
- out_b  output  WIDTH  operand b to the MAC
- out_first  output  1  current output pair is element 0 of its vector
- out_last  output  1  current output pair is the final element of its vector
- vec_done  output  1  one-cycle pulse, the cycle after the last element pops
- count  output  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst high at an edge) sets:
  - pointers 0, count 0, idx 0, len_q 0, vec_done 0;
  - out_valid 0, out_a/out_b 0 (storage read data is masked while empty).
  - in_ready is 0 while rst is high and 1 from the first cycle after.
- Push: in_valid && in_ready. in_ready = (count != DEPTH). Pushes are refused when full even if a pop occurs in the same cycle.
- Pop: out_valid && out_ready. out_valid = (count != 0).
- out_a/out_b/out_first/out_last are valid whenever out_valid is high and hold stable while out_valid && !out_ready.
- Latency: a pair pushed at edge N is presented from cycle N+1 (without the bypass feature).
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Order is strictly FIFO.
- Framing counter idx (VLEN_W bits) counts popped elements of the current vector.
- Effective length: eff_len = (idx == 0) ? vec_len : len_q. A value of 0 is treated as 2^VLEN_W.
- When idx == 0 and a pop occurs, len_q <= vec_len. Changing vec_len mid-vector therefore has no effect until the next vector.
- out_first = (idx == 0); out_last = (idx == eff_len - 1). Both are asserted together when eff_len = 1.
- On a pop with out_last: idx <= 0 and vec_done pulses high in the next cycle. Otherwise a pop advances idx by 1.
- vec_done is never asserted for two consecutive cycles unless two last-pops occur back-to-back (e.g. eff_len = 1 stream).
- flush: same effect as rst on FIFO, idx, len_q and vec_done. flush has priority over a push or pop in the same cycle, and that push/pop is discarded.
- rst mid-vector: partial vector discarded; the next pop is out_first.
- No data-dependent behaviour; operands pass through unmodified.

Optional Feature:
- Macro: MAC_SEQ_BYPASS_EN.
- Defined: when count == 0 and in_valid is high:
  - out_valid = 1, out_a/out_b = in_a/in_b combinationally, and in_ready = 1;
  - if out_ready is also high the pair is consumed the same cycle without entering storage (count stays 0) and framing advances as a normal pop;
  - if out_ready is low the pair is written to the FIFO as a normal push.
- Not defined: no combinational in-to-out path; minimum latency is 1 cycle.

Test Plan:
- Reset then idle: rst 1 for 2 cycles -> out_valid 0, count 0, vec_done 0, in_ready 0 during reset and 1 after.
- vec_len=4, push (3,2),(1,4),(5,3),(7,2) with out_ready=1 -> four pops in order, out_first only on (3,2), out_last only on (7,2), vec_done pulse one cycle after (7,2).
- Backpressure: out_ready=0, push 5 pairs -> in_ready drops after the 4th, count=4, 5th pair not accepted. Release out_ready -> pairs drain in order, count returns to 0.
- Length edge cases:
  - vec_len=1, stream (1,1),(0,0) -> each pop has first=last=1 and vec_done pulses for each;
  - vec_len=0 -> last on the 16th element.
- vec_len changed from 4 to 2 after the 2nd pop -> current vector still ends on element 4, next vector ends on element 2.
- Flush with 3 entries and idx=2 while push and pop are asserted -> next cycle count=0, out_valid 0, next pair is out_first. With MAC_SEQ_BYPASS_EN: empty FIFO, in_valid with (3,2) and out_ready=1 -> out_valid same cycle with (3,2), count stays 0.
